// File: rtl/dds_sweep_ctrl.sv
// Frequency-sweep controller for a DDS phase accumulator.
// Steps freq_cntrl from f_start toward f_stop by f_step, holding each value for dwell+1
// cycles. Supports a one-shot up-sweep or a continuous triangle sweep. Configuration is
// latched at start so inputs may change freely while a sweep runs.
module dds_sweep_ctrl #(
  parameter int unsigned FW = 16,
  parameter int unsigned DW = 16
) (
  input  logic          clk,
  input  logic          res_n,
  input  logic          start,
  input  logic          stop,
  input  logic          mode,
  input  logic [FW-1:0] f_start,
  input  logic [FW-1:0] f_stop,
  input  logic [FW-1:0] f_step,
  input  logic [DW-1:0] dwell,
  output logic [FW-1:0] freq_cntrl,
  output logic          busy,
  output logic          done,
  output logic          dir
);

  typedef enum logic [1:0] {StIdle, StUp, StDown} state_e;

  state_e        state_q, state_d;
  logic [FW-1:0] freq_q, freq_d;
  logic [DW-1:0] cnt_q, cnt_d;
  logic          done_q, done_d;
  logic          busy_q, busy_d;
  logic          dir_q, dir_d;

  // Latched sweep configuration
  logic          mode_q, mode_d;
  logic [FW-1:0] fstart_q, fstart_d;
  logic [FW-1:0] fstop_q, fstop_d;
  logic [FW-1:0] fstep_q, fstep_d;
  logic [DW-1:0] dwell_q, dwell_d;

  logic [FW:0]   sum;
  logic [FW-1:0] diff;
  logic [FW-1:0] up_next;
  logic [FW-1:0] dn_next;
  logic          expire;

  // Saturating step arithmetic: sum in FW+1 bits so it never wraps, difference checked for
  // underflow before use.
  always_comb begin
    sum     = {1'b0, freq_q} + {1'b0, fstep_q};
    diff    = freq_q - fstep_q;
    up_next = (sum >= {1'b0, fstop_q}) ? fstop_q : sum[FW-1:0];
    dn_next = ((freq_q < fstep_q) || (diff < fstart_q)) ? fstart_q : diff;
    expire  = (cnt_q == dwell_q);
  end

  // Next-state and output logic
  always_comb begin
    state_d  = state_q;
    freq_d   = freq_q;
    cnt_d    = cnt_q;
    done_d   = 1'b0;
    mode_d   = mode_q;
    fstart_d = fstart_q;
    fstop_d  = fstop_q;
    fstep_d  = fstep_q;
    dwell_d  = dwell_q;

    unique case (state_q)
      StIdle: begin
        // stop wins over start, leaving everything untouched
        if (start && !stop) begin
          mode_d   = mode;
          fstart_d = f_start;
          fstop_d  = f_stop;
          fstep_d  = f_step;
          dwell_d  = dwell;
          freq_d   = f_start;
          cnt_d    = '0;
          if ((f_step == '0) || (f_stop <= f_start)) begin
            done_d = 1'b1;
          end else begin
            state_d = StUp;
          end
        end
      end
      StUp: begin
        if (stop) begin
          state_d = StIdle;
          cnt_d   = '0;
        end else if (expire) begin
          cnt_d = '0;
          if (freq_q < fstop_q) begin
            freq_d = up_next;
          end else if (mode_q) begin
            state_d = StDown;
            freq_d  = dn_next;
          end else begin
            state_d = StIdle;
            done_d  = 1'b1;
          end
        end else begin
          cnt_d = cnt_q + DW'(1);
        end
      end
      StDown: begin
        if (stop) begin
          state_d = StIdle;
          cnt_d   = '0;
        end else if (expire) begin
          cnt_d = '0;
          if (freq_q > fstart_q) begin
            freq_d = dn_next;
          end else begin
            // freq_q equals fstart_q here, so up_next is min(f_start+f_step, f_stop)
            state_d = StUp;
            freq_d  = up_next;
          end
        end else begin
          cnt_d = cnt_q + DW'(1);
        end
      end
      default: state_d = StIdle;
    endcase

    busy_d = (state_d != StIdle);
    dir_d  = (state_d == StDown);
  end

  // State and output registers with asynchronous reset
  always_ff @(posedge clk or negedge res_n) begin
    if (!res_n) begin
      state_q  <= StIdle;
      freq_q   <= '0;
      cnt_q    <= '0;
      done_q   <= 1'b0;
      busy_q   <= 1'b0;
      dir_q    <= 1'b0;
      mode_q   <= 1'b0;
      fstart_q <= '0;
      fstop_q  <= '0;
      fstep_q  <= '0;
      dwell_q  <= '0;
    end else begin
      state_q  <= state_d;
      freq_q   <= freq_d;
      cnt_q    <= cnt_d;
      done_q   <= done_d;
      busy_q   <= busy_d;
      dir_q    <= dir_d;
      mode_q   <= mode_d;
      fstart_q <= fstart_d;
      fstop_q  <= fstop_d;
      fstep_q  <= fstep_d;
      dwell_q  <= dwell_d;
    end
  end

  assign freq_cntrl = freq_q;
  assign busy       = busy_q;
  assign done       = done_q;
  assign dir        = dir_q;

endmodule

// File: tb/tb_dds_sweep_ctrl.sv
// Directed testbench for dds_sweep_ctrl with hand-computed expected sequences.
module tb_dds_sweep_ctrl;

  logic        clk = 1'b0;
  logic        res_n;
  logic        start;
  logic        stop;
  logic        mode;
  logic [15:0] f_start;
  logic [15:0] f_stop;
  logic [15:0] f_step;
  logic [15:0] dwell;
  logic [15:0] freq_cntrl;
  logic        busy;
  logic        done;
  logic        dir;

  int errors = 0;
  int checks = 0;

  dds_sweep_ctrl #(.FW(16), .DW(16)) dut (
    .clk        (clk),
    .res_n      (res_n),
    .start      (start),
    .stop       (stop),
    .mode       (mode),
    .f_start    (f_start),
    .f_stop     (f_stop),
    .f_step     (f_step),
    .dwell      (dwell),
    .freq_cntrl (freq_cntrl),
    .busy       (busy),
    .done       (done),
    .dir        (dir)
  );

  always #5 clk = ~clk;

  // Advance one rising edge and settle just after it
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic set_cfg(input logic [15:0] fs, input logic [15:0] fe, input logic [15:0] st,
                         input logic [15:0] dw, input logic md);
    f_start = fs;
    f_stop  = fe;
    f_step  = st;
    dwell   = dw;
    mode    = md;
  endtask

  // Start pulse: the edge consumed here is edge T
  task automatic pulse_start();
    start = 1'b1;
    tick();
    start = 1'b0;
  endtask

  task automatic test_reset();
    res_n = 1'b0;
    start = 1'b0;
    stop  = 1'b0;
    set_cfg(16'd0, 16'd0, 16'd0, 16'd0, 1'b0);
    tick();
    tick();
    checks++;
    if ({freq_cntrl, busy, done, dir} !== 19'd0) begin
      errors++;
      $display("FAIL reset_outputs got freq=%0d busy=%0b done=%0b dir=%0b want all 0",
               freq_cntrl, busy, done, dir);
    end
    res_n = 1'b1;
    tick();
    checks++;
    if (busy !== 1'b0 || freq_cntrl !== 16'd0) begin
      errors++;
      $display("FAIL reset_release_idle got busy=%0b freq=%0d want 0/0", busy, freq_cntrl);
    end
  endtask

  task automatic test_one_shot();
    int exp_f[10] = '{100, 100, 110, 110, 120, 120, 130, 130, 130, 130};
    int exp_done[10] = '{0, 0, 0, 0, 0, 0, 0, 0, 1, 0};
    int exp_busy[10] = '{1, 1, 1, 1, 1, 1, 1, 1, 0, 0};
    set_cfg(16'd100, 16'd130, 16'd10, 16'd1, 1'b0);
    pulse_start();
    // Changing live inputs must not disturb the latched configuration
    set_cfg(16'd5, 16'd999, 16'd1, 16'd7, 1'b1);
    for (int k = 0; k < 10; k++) begin
      if (k > 0) tick();
      checks++;
      if (freq_cntrl !== 16'(exp_f[k]) || done !== 1'(exp_done[k]) ||
          busy !== 1'(exp_busy[k]) || dir !== 1'b0) begin
        errors++;
        $display("FAIL one_shot k=%0d got freq=%0d done=%0b busy=%0b dir=%0b want %0d/%0d/%0d/0",
                 k, freq_cntrl, done, busy, dir, exp_f[k], exp_done[k], exp_busy[k]);
      end
    end
  endtask

  task automatic test_triangle();
    int exp_f[10] = '{100, 110, 120, 125, 115, 105, 100, 110, 120, 125};
    int exp_dir[10] = '{0, 0, 0, 0, 1, 1, 1, 0, 0, 0};
    set_cfg(16'd100, 16'd125, 16'd10, 16'd0, 1'b1);
    pulse_start();
    for (int k = 0; k < 10; k++) begin
      if (k > 0) tick();
      checks++;
      if (freq_cntrl !== 16'(exp_f[k]) || dir !== 1'(exp_dir[k]) ||
          busy !== 1'b1 || done !== 1'b0) begin
        errors++;
        $display("FAIL triangle k=%0d got freq=%0d dir=%0b busy=%0b done=%0b want %0d/%0d/1/0",
                 k, freq_cntrl, dir, busy, done, exp_f[k], exp_dir[k]);
      end
    end
    // Stop during the triangle: holds 125, back to idle
    stop = 1'b1;
    tick();
    stop = 1'b0;
    checks++;
    if (busy !== 1'b0 || done !== 1'b0 || dir !== 1'b0 || freq_cntrl !== 16'd125) begin
      errors++;
      $display("FAIL triangle_stop got freq=%0d busy=%0b done=%0b dir=%0b want 125/0/0/0",
               freq_cntrl, busy, done, dir);
    end
  endtask

  task automatic test_stop();
    set_cfg(16'd100, 16'd130, 16'd10, 16'd1, 1'b0);
    pulse_start();
    for (int k = 0; k < 4; k++) tick();
    checks++;
    if (freq_cntrl !== 16'd120 || busy !== 1'b1) begin
      errors++;
      $display("FAIL stop_pre got freq=%0d busy=%0b want 120/1", freq_cntrl, busy);
    end
    stop = 1'b1;
    tick();
    stop = 1'b0;
    for (int k = 0; k < 6; k++) begin
      checks++;
      if (freq_cntrl !== 16'd120 || busy !== 1'b0 || done !== 1'b0) begin
        errors++;
        $display("FAIL stop_hold k=%0d got freq=%0d busy=%0b done=%0b want 120/0/0",
                 k, freq_cntrl, busy, done);
      end
      tick();
    end
  endtask

  task automatic test_saturation();
    int exp_f[4] = '{16'hFFF0, 16'hFFFF, 16'hFFFF, 16'hFFFF};
    int exp_done[4] = '{0, 0, 1, 0};
    set_cfg(16'hFFF0, 16'hFFFF, 16'h0020, 16'd0, 1'b0);
    pulse_start();
    for (int k = 0; k < 4; k++) begin
      if (k > 0) tick();
      checks++;
      if (freq_cntrl !== 16'(exp_f[k]) || done !== 1'(exp_done[k])) begin
        errors++;
        $display("FAIL saturation k=%0d got freq=%h done=%0b want %h/%0d",
                 k, freq_cntrl, done, exp_f[k], exp_done[k]);
      end
    end
  endtask

  task automatic test_degenerate();
    // Zero step
    set_cfg(16'd50, 16'd90, 16'd0, 16'd3, 1'b0);
    pulse_start();
    checks++;
    if (freq_cntrl !== 16'd50 || done !== 1'b1 || busy !== 1'b0) begin
      errors++;
      $display("FAIL degen_step0 got freq=%0d done=%0b busy=%0b want 50/1/0",
               freq_cntrl, done, busy);
    end
    tick();
    checks++;
    if (done !== 1'b0 || busy !== 1'b0) begin
      errors++;
      $display("FAIL degen_step0_after got done=%0b busy=%0b want 0/0", done, busy);
    end
    // f_stop below f_start
    set_cfg(16'd200, 16'd150, 16'd5, 16'd0, 1'b1);
    pulse_start();
    checks++;
    if (freq_cntrl !== 16'd200 || done !== 1'b1 || busy !== 1'b0) begin
      errors++;
      $display("FAIL degen_order got freq=%0d done=%0b busy=%0b want 200/1/0",
               freq_cntrl, done, busy);
    end
  endtask

  task automatic test_back_to_back();
    int exp_f[4] = '{100, 100, 110, 110};
    set_cfg(16'd100, 16'd130, 16'd10, 16'd1, 1'b0);
    pulse_start();
    // Re-assert start with a new config while busy; it must be ignored
    start = 1'b1;
    set_cfg(16'd500, 16'd900, 16'd50, 16'd0, 1'b1);
    for (int k = 1; k < 4; k++) begin
      tick();
      checks++;
      if (freq_cntrl !== 16'(exp_f[k]) || busy !== 1'b1 || done !== 1'b0) begin
        errors++;
        $display("FAIL start_busy k=%0d got freq=%0d busy=%0b done=%0b want %0d/1/0",
                 k, freq_cntrl, busy, done, exp_f[k]);
      end
    end
    start = 1'b0;
    stop  = 1'b1;
    tick();
    stop  = 1'b0;
    // start and stop together in idle: nothing happens
    start = 1'b1;
    stop  = 1'b1;
    tick();
    start = 1'b0;
    stop  = 1'b0;
    checks++;
    if (freq_cntrl !== 16'd110 || busy !== 1'b0 || done !== 1'b0) begin
      errors++;
      $display("FAIL start_stop_idle got freq=%0d busy=%0b done=%0b want 110/0/0",
               freq_cntrl, busy, done);
    end
  endtask

  task automatic test_async_reset();
    set_cfg(16'd100, 16'd130, 16'd10, 16'd0, 1'b1);
    pulse_start();
    tick();
    tick();
    checks++;
    if (freq_cntrl !== 16'd120 || busy !== 1'b1) begin
      errors++;
      $display("FAIL areset_pre got freq=%0d busy=%0b want 120/1", freq_cntrl, busy);
    end
    // Assert reset between edges
    #2;
    res_n = 1'b0;
    #1;
    checks++;
    if ({freq_cntrl, busy, done, dir} !== 19'd0) begin
      errors++;
      $display("FAIL areset_async got freq=%0d busy=%0b done=%0b dir=%0b want all 0",
               freq_cntrl, busy, done, dir);
    end
    #2;
    res_n = 1'b1;
    tick();
    tick();
    checks++;
    if (busy !== 1'b0 || freq_cntrl !== 16'd0) begin
      errors++;
      $display("FAIL areset_waits got busy=%0b freq=%0d want 0/0", busy, freq_cntrl);
    end
    set_cfg(16'd100, 16'd130, 16'd10, 16'd0, 1'b0);
    pulse_start();
    checks++;
    if (freq_cntrl !== 16'd100 || busy !== 1'b1) begin
      errors++;
      $display("FAIL areset_fresh got freq=%0d busy=%0b want 100/1", freq_cntrl, busy);
    end
    tick();
    checks++;
    if (freq_cntrl !== 16'd110) begin
      errors++;
      $display("FAIL areset_fresh_step got freq=%0d want 110", freq_cntrl);
    end
  endtask

  initial begin
    test_reset();
    test_one_shot();
    test_triangle();
    test_stop();
    test_saturation();
    test_degenerate();
    test_back_to_back();
    test_async_reset();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
